// File: rtl/cart_bank_mapper.sv
// rtl/cart_bank_mapper.sv - table-driven 7800 cartridge window mapper with pclk1-committed bank registers
// Optional XM-style XCTRL1 register at $470 enabled by defining CART_BANK_XCTRL_EN.
module cart_bank_mapper #(
    parameter int          NUM_WINDOWS   = 8,
    parameter int          NUM_BANK_REGS = 4,
    parameter int          BANK_W        = 8,
    parameter int          ROM_ADDR_W    = 25,
    parameter int          RAM_ADDR_W    = 15,
    parameter logic [15:0] BANK_DEC_BASE = 16'h8000,
    parameter logic [15:0] BANK_DEC_MASK = 16'hC000,
    localparam int WIN_W = $clog2(NUM_WINDOWS),
    localparam int OFF_W = 16 - WIN_W,
    localparam int IDX_W = (NUM_BANK_REGS > 1) ? $clog2(NUM_BANK_REGS) : 1,
    localparam int CFG_W = BANK_W + 6
) (
    input  logic                  clk_sys,
    input  logic                  reset_n,
    input  logic                  pclk0,
    input  logic                  pclk1,
    input  logic [15:0]           address_in,
    input  logic [7:0]            din,
    input  logic                  rw,
    input  logic                  cart_cs,
    input  logic [BANK_W-1:0]     bank_mask,
    input  logic                  cfg_we,
    input  logic [WIN_W-1:0]      cfg_idx,
    input  logic [CFG_W-1:0]      cfg_data,
    output logic [ROM_ADDR_W-1:0] rom_address,
    output logic                  rom_cs,
    output logic [RAM_ADDR_W-1:0] ram_address,
    output logic                  ram_we,
    output logic                  ram_cs,
    output logic                  bus_oe,
`ifdef CART_BANK_XCTRL_EN
    output logic [7:0]            xctrl_dout,
    output logic                  xctrl_oe,
`endif
    output logic                  bank_pending
);

    localparam logic [IDX_W-1:0] IDX_MASK = IDX_W'(NUM_BANK_REGS - 1);

    typedef enum logic {IDLE, PEND} state_t;

    state_t             state;
    logic [2:0]         tbl_type   [NUM_WINDOWS];
    logic [IDX_W-1:0]   tbl_regsel [NUM_WINDOWS];
    logic [BANK_W-1:0]  tbl_bank   [NUM_WINDOWS];
    logic [BANK_W-1:0]  bank_regs  [2**IDX_W];
    logic [IDX_W-1:0]   stage_idx;
    logic [BANK_W-1:0]  stage_val;

    wire cpu_wr   = ~rw & cart_cs & pclk0;
    wire bank_hit = cpu_wr & ((address_in & BANK_DEC_MASK) == BANK_DEC_BASE);
    wire [IDX_W-1:0]  hit_idx = address_in[IDX_W-1:0] & IDX_MASK;
    wire [BANK_W-1:0] hit_val = BANK_W'(din) & bank_mask;
    wire unused_cfg_regsel = ^cfg_data[BANK_W+2:BANK_W];

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_WINDOWS; i++) begin
                tbl_type[i]   <= 3'd0;
                tbl_regsel[i] <= '0;
                tbl_bank[i]   <= '0;
            end
        end else if (cfg_we) begin
            tbl_type[cfg_idx]   <= cfg_data[CFG_W-1 -: 3];
            tbl_regsel[cfg_idx] <= cfg_data[BANK_W +: IDX_W] & IDX_MASK;
            tbl_bank[cfg_idx]   <= cfg_data[BANK_W-1:0];
        end
    end

    // A staged write lands on pclk1, or early if a second hit needs the staging slot.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            bank_pending <= 1'b0;
            stage_idx    <= '0;
            stage_val    <= '0;
            for (int i = 0; i < 2**IDX_W; i++) bank_regs[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bank_hit) begin
                        stage_idx    <= hit_idx;
                        stage_val    <= hit_val;
                        state        <= PEND;
                        bank_pending <= 1'b1;
                    end
                end
                PEND: begin
                    if (bank_hit || pclk1) bank_regs[stage_idx] <= stage_val;
                    if (bank_hit) begin
                        stage_idx <= hit_idx;
                        stage_val <= hit_val;
                    end else if (pclk1) begin
                        state        <= IDLE;
                        bank_pending <= 1'b0;
                    end
                end
            endcase
        end
    end

`ifdef CART_BANK_XCTRL_EN
    localparam logic [WIN_W-1:0] WIN_4000 = WIN_W'(16'h4000 >> OFF_W);
    localparam logic [WIN_W-1:0] WIN_6000 = WIN_W'(16'h6000 >> OFF_W);

    logic [7:0] xctrl1;
    wire xctrl_hit = cart_cs & (address_in == 16'h0470);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n)
            xctrl1 <= 8'h00;
        else if (cpu_wr && xctrl_hit)
            xctrl1 <= din;
    end

    assign xctrl_dout = xctrl1;
    assign xctrl_oe   = xctrl_hit & rw;
`endif

    logic [WIN_W-1:0]         win;
    logic [OFF_W-1:0]         off;
    logic [2:0]               eff_type;
    logic [BANK_W-1:0]        bank;
    logic [BANK_W+OFF_W-1:0]  lin;
    logic                     rom_sel;
    logic                     ram_sel;

    always_comb begin
        win      = address_in[15:OFF_W];
        off      = address_in[OFF_W-1:0];
        eff_type = tbl_type[win];
`ifdef CART_BANK_XCTRL_EN
        if ((xctrl1[5] && win == WIN_4000) || (xctrl1[6] && win == WIN_6000))
            eff_type = 3'd3;
`endif
        bank    = (eff_type == 3'd1) ? tbl_bank[win] : bank_regs[tbl_regsel[win]];
        lin     = {bank, off};
        rom_sel = cart_cs & ((eff_type == 3'd1) | (eff_type == 3'd2));
        ram_sel = cart_cs & (eff_type == 3'd3);
    end

    assign rom_cs      = rom_sel;
    assign ram_cs      = ram_sel;
    assign rom_address = rom_sel ? ROM_ADDR_W'(lin) : '0;
    assign ram_address = ram_sel ? RAM_ADDR_W'(lin) : '0;
    assign ram_we      = ram_sel & ~rw & pclk0;
    assign bus_oe      = (rom_sel | ram_sel) & rw;

endmodule

// File: tb/tb_cart_bank_mapper.sv
// tb/tb_cart_bank_mapper.sv - self-checking bench for cart_bank_mapper with a queue-based reference model
module tb_cart_bank_mapper;

    localparam int NW  = 8;
    localparam int NB  = 4;
    localparam int WSZ = 65536 / NW;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        pclk0 = 1'b0, pclk1 = 1'b0;
    logic [15:0] address_in = '0;
    logic [7:0]  din = '0;
    logic        rw = 1'b1;
    logic        cart_cs = 1'b0;
    logic [7:0]  bank_mask = 8'hFF;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_idx = '0;
    logic [13:0] cfg_data = '0;
    logic [24:0] rom_address;
    logic        rom_cs;
    logic [14:0] ram_address;
    logic        ram_we, ram_cs, bus_oe, bank_pending;
`ifdef CART_BANK_XCTRL_EN
    logic [7:0]  xctrl_dout;
    logic        xctrl_oe;
`endif

    int checks = 0;
    int failures = 0;

    typedef struct {int idx; int val;} wr_t;
    wr_t stage_q[$];
    int  m_type[NW], m_regsel[NW], m_bank[NW], m_breg[NB];
    int  m_xc;

    cart_bank_mapper dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .pclk0(pclk0), .pclk1(pclk1),
        .address_in(address_in), .din(din), .rw(rw), .cart_cs(cart_cs),
        .bank_mask(bank_mask), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_data(cfg_data),
        .rom_address(rom_address), .rom_cs(rom_cs), .ram_address(ram_address),
        .ram_we(ram_we), .ram_cs(ram_cs), .bus_oe(bus_oe),
`ifdef CART_BANK_XCTRL_EN
        .xctrl_dout(xctrl_dout), .xctrl_oe(xctrl_oe),
`endif
        .bank_pending(bank_pending)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic model_clear();
        for (int i = 0; i < NW; i++) begin m_type[i] = 0; m_regsel[i] = 0; m_bank[i] = 0; end
        for (int i = 0; i < NB; i++) m_breg[i] = 0;
        stage_q.delete();
        m_xc = 0;
    endtask

    // Reference behaviour at a clock edge, from the inputs presented during that cycle.
    task automatic model_edge();
        bit hit;
        hit = !rw && cart_cs && pclk0 && ((address_in & 16'hC000) == 16'h8000);
        if (cfg_we) begin
            m_type[cfg_idx]   = int'(cfg_data[13:11]);
            m_regsel[cfg_idx] = int'(cfg_data[10:8]);
            m_bank[cfg_idx]   = int'(cfg_data[7:0]);
        end
        if (stage_q.size() > 0 && (hit || pclk1)) begin
            m_breg[stage_q[0].idx] = stage_q[0].val;
            void'(stage_q.pop_front());
        end
        if (hit) stage_q.push_back('{idx: int'(address_in) % NB, val: int'(din & bank_mask)});
`ifdef CART_BANK_XCTRL_EN
        if (!rw && cart_cs && pclk0 && address_in == 16'h0470) m_xc = int'(din);
`endif
    endtask

    function automatic void model_out(output logic [24:0] e_rom, output logic e_rcs,
                                      output logic [14:0] e_ram, output logic e_mcs,
                                      output logic e_we, output logic e_oe);
        int w, o, t, bank;
        longint lin;
        w = int'(address_in) / WSZ;
        o = int'(address_in) % WSZ;
        t = m_type[w];
        if ((m_xc & 32'h20) != 0 && w == 16'h4000 / WSZ) t = 3;
        if ((m_xc & 32'h40) != 0 && w == 16'h6000 / WSZ) t = 3;
        bank  = (t == 1) ? m_bank[w] : m_breg[m_regsel[w] % NB];
        lin   = longint'(bank) * WSZ + o;
        e_rcs = cart_cs && (t == 1 || t == 2);
        e_mcs = cart_cs && (t == 3);
        e_oe  = cart_cs && rw && (t >= 1 && t <= 3);
        e_we  = e_mcs && !rw && pclk0;
        e_rom = e_rcs ? lin[24:0] : '0;
        e_ram = e_mcs ? lin[14:0] : '0;
    endfunction

    task automatic tick();
        @(posedge clk_sys);
        model_edge();
        #1;
    endtask

    task automatic bus(input logic [15:0] a, input logic [7:0] d, input logic r,
                       input logic p0, input logic p1);
        address_in = a; din = d; rw = r; cart_cs = 1'b1; pclk0 = p0; pclk1 = p1;
    endtask

    task automatic cfg(input int idx, input int typ, input int rs, input int bk);
        bus(16'h0000, 8'h00, 1'b1, 1'b0, 1'b0);
        cfg_we = 1'b1; cfg_idx = 3'(idx); cfg_data = {3'(typ), 3'(rs), 8'(bk)};
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        model_clear();
        @(negedge clk_sys);
        reset_n = 1'b1;
        @(posedge clk_sys);
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        bus(16'hC000, 8'h00, 1'b1, 1'b0, 1'b0);
        @(negedge clk_sys);
        checks++; if (rom_cs !== 1'b0) begin failures++; $display("FAIL reset_rom_cs got=%b exp=0", rom_cs); end
        checks++; if (ram_cs !== 1'b0) begin failures++; $display("FAIL reset_ram_cs got=%b exp=0", ram_cs); end
        checks++; if (bus_oe !== 1'b0) begin failures++; $display("FAIL reset_bus_oe got=%b exp=0", bus_oe); end
        checks++; if (bank_pending !== 1'b0) begin failures++; $display("FAIL reset_pending got=%b exp=0", bank_pending); end
        tick();
    endtask

    task automatic test_fixed_rom();
        cfg(7, 1, 0, 8'h07);
        bus(16'hE123, 8'h00, 1'b1, 1'b0, 1'b0);
        @(negedge clk_sys);
        checks++; if (rom_address !== 25'h0E123) begin failures++; $display("FAIL fixed_rom_addr got=%h exp=0e123", rom_address); end
        checks++; if (rom_cs !== 1'b1) begin failures++; $display("FAIL fixed_rom_cs got=%b exp=1", rom_cs); end
        checks++; if (bus_oe !== 1'b1) begin failures++; $display("FAIL fixed_rom_oe got=%b exp=1", bus_oe); end
        tick();
        cfg(6, 5, 0, 8'h33);
        bus(16'hC000, 8'h00, 1'b1, 1'b0, 1'b0);
        @(negedge clk_sys);
        checks++; if ({rom_cs, ram_cs, bus_oe} !== 3'b000) begin failures++; $display("FAIL type5_open got=%b exp=000", {rom_cs, ram_cs, bus_oe}); end
        tick();
    endtask

    task automatic test_bank_commit();
        cfg(4, 2, 0, 0);
        bank_mask = 8'h07;
        bus(16'h8000, 8'h0D, 1'b0, 1'b1, 1'b0);
        tick();
        bus(16'h8010, 8'h00, 1'b1, 1'b0, 1'b0);
        @(negedge clk_sys);
        checks++; if (bank_pending !== 1'b1) begin failures++; $display("FAIL commit_pending got=%b exp=1", bank_pending); end
        checks++; if (rom_address !== 25'h00010) begin failures++; $display("FAIL commit_early got=%h exp=00010", rom_address); end
        tick();
        @(negedge clk_sys);
        checks++; if (rom_address !== 25'h00010) begin failures++; $display("FAIL commit_hold got=%h exp=00010", rom_address); end
        pclk1 = 1'b1;
        tick();
        pclk1 = 1'b0;
        @(negedge clk_sys);
        checks++; if (bank_pending !== 1'b0) begin failures++; $display("FAIL commit_clear got=%b exp=0", bank_pending); end
        checks++; if (rom_address !== 25'h0A010) begin failures++; $display("FAIL commit_addr got=%h exp=0a010", rom_address); end
        tick();
    endtask

    task automatic test_double_hit();
        cfg(5, 2, 1, 0);
        bus(16'h8000, 8'h01, 1'b0, 1'b1, 1'b0);
        tick();
        bus(16'h8001, 8'h02, 1'b0, 1'b1, 1'b0);
        tick();
        bus(16'h8010, 8'h00, 1'b1, 1'b0, 1'b0);
        @(negedge clk_sys);
        checks++; if (rom_address !== 25'h02010) begin failures++; $display("FAIL dbl_reg0 got=%h exp=02010", rom_address); end
        address_in = 16'hA010;
        #1;
        checks++; if (rom_address !== 25'h00010) begin failures++; $display("FAIL dbl_reg1_early got=%h exp=00010", rom_address); end
        pclk1 = 1'b1;
        tick();
        bus(16'hA010, 8'h00, 1'b1, 1'b0, 1'b0);
        @(negedge clk_sys);
        checks++; if (rom_address !== 25'h04010) begin failures++; $display("FAIL dbl_reg1 got=%h exp=04010", rom_address); end
        tick();
        // Hit and pclk1 together while idle: only stages.
        bus(16'h8001, 8'h03, 1'b0, 1'b1, 1'b1);
        tick();
        bus(16'hA010, 8'h00, 1'b1, 1'b0, 1'b0);
        @(negedge clk_sys);
        checks++; if (bank_pending !== 1'b1) begin failures++; $display("FAIL idle_both_pending got=%b exp=1", bank_pending); end
        checks++; if (rom_address !== 25'h04010) begin failures++; $display("FAIL idle_both_addr got=%h exp=04010", rom_address); end
        pclk1 = 1'b1;
        tick();
        pclk1 = 1'b0;
    endtask

    task automatic test_ram();
        bus(16'h8000, 8'h00, 1'b0, 1'b1, 1'b0);
        tick();
        bus(16'h0000, 8'h00, 1'b1, 1'b0, 1'b1);
        tick();
        cfg(2, 3, 0, 0);
        bus(16'h4005, 8'hA5, 1'b0, 1'b1, 1'b0);
        @(negedge clk_sys);
        checks++; if (ram_we !== 1'b1) begin failures++; $display("FAIL ram_we_on got=%b exp=1", ram_we); end
        checks++; if (ram_address !== 15'h0005) begin failures++; $display("FAIL ram_addr got=%h exp=0005", ram_address); end
        checks++; if ({ram_cs, rom_cs, bus_oe} !== 3'b100) begin failures++; $display("FAIL ram_sel got=%b exp=100", {ram_cs, rom_cs, bus_oe}); end
        pclk0 = 1'b0;
        #1;
        checks++; if (ram_we !== 1'b0) begin failures++; $display("FAIL ram_we_off got=%b exp=0", ram_we); end
        tick();
        // RAM window that also decodes as a bank write: both happen.
        cfg(4, 3, 0, 0);
        bus(16'h8002, 8'h06, 1'b0, 1'b1, 1'b0);
        @(negedge clk_sys);
        checks++; if (ram_we !== 1'b1) begin failures++; $display("FAIL both_ram_we got=%b exp=1", ram_we); end
        tick();
        bus(16'h8002, 8'h00, 1'b1, 1'b0, 1'b0);
        @(negedge clk_sys);
        checks++; if (bank_pending !== 1'b1) begin failures++; $display("FAIL both_pending got=%b exp=1", bank_pending); end
        pclk1 = 1'b1;
        tick();
        pclk1 = 1'b0;
    endtask

    task automatic test_reset_discard();
        bus(16'h8003, 8'h07, 1'b0, 1'b1, 1'b0);
        tick();
        pclk0 = 1'b0;
        apply_reset();
        checks++; if (bank_pending !== 1'b0) begin failures++; $display("FAIL discard_pending got=%b exp=0", bank_pending); end
        cfg(4, 2, 3, 0);
        bus(16'h8010, 8'h00, 1'b1, 1'b0, 1'b1);
        tick();
        pclk1 = 1'b0;
        @(negedge clk_sys);
        checks++; if (rom_address !== 25'h00010) begin failures++; $display("FAIL discard_addr got=%h exp=00010", rom_address); end
        tick();
    endtask

`ifdef CART_BANK_XCTRL_EN
    task automatic test_xctrl();
        bus(16'h0470, 8'h20, 1'b0, 1'b1, 1'b0);
        tick();
        bus(16'h4000, 8'h00, 1'b1, 1'b0, 1'b0);
        @(negedge clk_sys);
        checks++; if (ram_cs !== 1'b1) begin failures++; $display("FAIL xctrl_force_ram got=%b exp=1", ram_cs); end
        address_in = 16'h0470;
        #1;
        checks++; if (xctrl_dout !== 8'h20) begin failures++; $display("FAIL xctrl_dout got=%h exp=20", xctrl_dout); end
        checks++; if (xctrl_oe !== 1'b1) begin failures++; $display("FAIL xctrl_oe got=%b exp=1", xctrl_oe); end
        tick();
    endtask
`endif

    task automatic test_random();
        logic [24:0] e_rom;
        logic [14:0] e_ram;
        logic e_rcs, e_mcs, e_we, e_oe;
        for (int c = 0; c < 500; c++) begin
            address_in = ($urandom_range(0, 9) < 4) ? (16'h8000 | 16'($urandom_range(0, 7)))
                                                    : 16'($urandom);
            din       = 8'($urandom);
            rw        = 1'($urandom_range(0, 1));
            cart_cs   = ($urandom_range(0, 9) != 0);
            pclk0     = ($urandom_range(0, 9) < 3);
            pclk1     = ($urandom_range(0, 9) < 2);
            bank_mask = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'($urandom);
            cfg_we    = ($urandom_range(0, 9) == 0);
            cfg_idx   = 3'($urandom);
            cfg_data  = 14'($urandom);
            @(negedge clk_sys);
            model_out(e_rom, e_rcs, e_ram, e_mcs, e_we, e_oe);
            checks++; if (rom_address !== e_rom) begin failures++; $display("FAIL rnd_rom_addr cyc=%0d got=%h exp=%h", c, rom_address, e_rom); end
            checks++; if (rom_cs !== e_rcs) begin failures++; $display("FAIL rnd_rom_cs cyc=%0d got=%b exp=%b", c, rom_cs, e_rcs); end
            checks++; if (ram_address !== e_ram) begin failures++; $display("FAIL rnd_ram_addr cyc=%0d got=%h exp=%h", c, ram_address, e_ram); end
            checks++; if (ram_cs !== e_mcs) begin failures++; $display("FAIL rnd_ram_cs cyc=%0d got=%b exp=%b", c, ram_cs, e_mcs); end
            checks++; if (ram_we !== e_we) begin failures++; $display("FAIL rnd_ram_we cyc=%0d got=%b exp=%b", c, ram_we, e_we); end
            checks++; if (bus_oe !== e_oe) begin failures++; $display("FAIL rnd_bus_oe cyc=%0d got=%b exp=%b", c, bus_oe, e_oe); end
            checks++; if (bank_pending !== (stage_q.size() != 0)) begin failures++; $display("FAIL rnd_pending cyc=%0d got=%b exp=%b", c, bank_pending, stage_q.size() != 0); end
            tick();
        end
        cfg_we = 1'b0;
    endtask

    initial begin
        model_clear();
        test_reset();
        test_fixed_rom();
        test_bank_commit();
        test_double_hit();
        test_ram();
        test_reset_discard();
`ifdef CART_BANK_XCTRL_EN
        test_xctrl();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
